// File: rtl/multicycle_controller_pkg.sv
// Purpose : shared encodings for the multicycle RISC-V control path (states, opcodes, mux selects, ALUOp).
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Ports   : none. The ALUOp codes are the same ones the existing ALU decoder consumes.
package riscv_mc_pkg;

  // Control FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t S_START    = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEMADR   = 4'd3;
  localparam state_t S_MEMREAD  = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_MEMWRITE = 4'd6;
  localparam state_t S_EXECR    = 4'd7;
  localparam state_t S_EXECI    = 4'd8;
  localparam state_t S_UPPER    = 4'd9;
  localparam state_t S_ALUWB    = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JAL      = 4'd12;
  localparam state_t S_TRAP     = 4'd13;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Immediate format select
  typedef logic [2:0] imm_src_t;
  localparam imm_src_t IMM_I = 3'b000;
  localparam imm_src_t IMM_S = 3'b001;
  localparam imm_src_t IMM_B = 3'b010;
  localparam imm_src_t IMM_J = 3'b011;
  localparam imm_src_t IMM_U = 3'b100;

  // ALU operand A select
  typedef logic [1:0] alu_src_a_t;
  localparam alu_src_a_t ALUA_PC    = 2'b00;
  localparam alu_src_a_t ALUA_OLDPC = 2'b01;
  localparam alu_src_a_t ALUA_RD1   = 2'b10;
  localparam alu_src_a_t ALUA_ZERO  = 2'b11;

  // ALU operand B select
  typedef logic [1:0] alu_src_b_t;
  localparam alu_src_b_t ALUB_RD2  = 2'b00;
  localparam alu_src_b_t ALUB_IMM  = 2'b01;
  localparam alu_src_b_t ALUB_FOUR = 2'b10;

  // Result mux select
  typedef logic [1:0] result_src_t;
  localparam result_src_t RES_ALUOUT    = 2'b00;
  localparam result_src_t RES_DATA      = 2'b01;
  localparam result_src_t RES_ALURESULT = 2'b10;

  // ALUOp, shared with the ALU decoder
  typedef logic [1:0] alu_op_t;
  localparam alu_op_t ALUOP_ADD   = 2'b00;
  localparam alu_op_t ALUOP_SUB   = 2'b01;
  localparam alu_op_t ALUOP_FUNCT = 2'b10;

  // State reached from DECODE for a given opcode; unknown opcodes trap.
  function automatic state_t decode_target(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_RTYPE:          nxt = S_EXECR;
      OP_ITYPE:          nxt = S_EXECI;
      OP_BRANCH:         nxt = S_BRANCH;
      OP_JAL:            nxt = S_JAL;
      OP_LUI, OP_AUIPC:  nxt = S_UPPER;
      default:           nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Purpose : bundle between the multicycle control FSM and the datapath/memory.
// Latency : n/a (wires only).
// Backpressure: mem_ready stalls the FSM while mem_req is high.
// Ports   : master = controller side (decode/flag inputs, control outputs); slave = datapath side.
interface multicycle_controller_if;
  import riscv_mc_pkg::*;

  // datapath -> controller
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic        mem_ready;

  // controller -> datapath
  logic        mem_req;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  result_src_t ResultSrc;
  alu_src_a_t  ALUSrcA;
  alu_src_b_t  ALUSrcB;
  imm_src_t    ImmSrc;
  alu_op_t     ALUOp;
  logic        retire;
  logic        illegal;

  modport master (
    input  op, funct3, zero, lt, ltu, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, retire, illegal
  );

  modport slave (
    output op, funct3, zero, lt, ltu, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, retire, illegal
  );

endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// Purpose : branch condition evaluation from funct3 and the rs1-rs2 ALU flags.
// Latency : combinational.
// Backpressure: none.
// Ports   : funct3, zero, lt, ltu in; take (branch taken), bad_funct3 (reserved encoding) out.
module branch_cond
  import riscv_mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       take,
  output logic       bad_funct3
);

  always_comb begin
    take       = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_BEQ:  take = zero;
      F3_BNE:  take = ~zero;
      F3_BLT:  take = lt;
      F3_BGE:  take = ~lt;
      F3_BLTU: take = ltu;
      F3_BGEU: take = ~ltu;
      default: bad_funct3 = 1'b1;  // 010 / 011 are not branches
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose : control FSM sequencing one RISC-V instruction over several cycles on a shared datapath.
// Latency : 3 (branch), 4 (sw/R/I/jal/lui/auipc), 5 (lw) cycles FETCH-to-retire with zero-wait memory.
// Backpressure: each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE holds the state and the request one cycle.
// Ports   : clk, rst_n (async active-low); bus (master modport) carries decode inputs, ALU flags,
//           memory handshake and all datapath selects/enables plus retire and sticky illegal.
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  state_t state;
  state_t state_nxt;
  logic   take;
  logic   bad_funct3;

  branch_cond u_branch_cond (
    .funct3     (bus.funct3),
    .zero       (bus.zero),
    .lt         (bus.lt),
    .ltu        (bus.ltu),
    .take       (take),
    .bad_funct3 (bad_funct3)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_START:    state_nxt = S_FETCH;
      S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = decode_target(bus.op);
      // op[5] separates store (0100011) from load (0000011)
      S_MEMADR:   state_nxt = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_UPPER,
      S_JAL:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = bad_funct3 ? S_TRAP : S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      // Unused encodings mean corrupted state: park in TRAP so it is visible.
      default:    state_nxt = S_TRAP;
    endcase
  end

  // Output decode: state only, except the enables that complete on mem_ready or branch outcome.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = ALUA_PC;
    bus.ALUSrcB   = ALUB_RD2;
    bus.ImmSrc    = IMM_I;
    bus.ALUOp     = ALUOP_ADD;
    bus.retire    = 1'b0;
    bus.illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 computed in the same cycle and written through ALUResult
        bus.mem_req   = 1'b1;
        bus.ALUSrcA   = ALUA_PC;
        bus.ALUSrcB   = ALUB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      S_DECODE: begin
        // Speculative target OldPC+imm into ALUOut; jal needs the J immediate instead of B.
        bus.ALUSrcA = ALUA_OLDPC;
        bus.ALUSrcB = ALUB_IMM;
        bus.ImmSrc  = (bus.op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        bus.ALUSrcA = ALUA_RD1;
        bus.ALUSrcB = ALUB_IMM;
        bus.ImmSrc  = bus.op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.retire   = bus.mem_ready;
      end
      S_EXECR: begin
        bus.ALUSrcA = ALUA_RD1;
        bus.ALUSrcB = ALUB_RD2;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        bus.ALUSrcA = ALUA_RD1;
        bus.ALUSrcB = ALUB_IMM;
        bus.ImmSrc  = IMM_I;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_UPPER: begin
        // lui = 0 + imm, auipc = OldPC + imm; op[5] tells them apart
        bus.ImmSrc  = IMM_U;
        bus.ALUSrcB = ALUB_IMM;
        bus.ALUSrcA = bus.op[5] ? ALUA_ZERO : ALUA_OLDPC;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs1-rs2 while PC loads the DECODE target held in ALUOut.
        bus.ALUSrcA   = ALUA_RD1;
        bus.ALUSrcB   = ALUB_RD2;
        bus.ALUOp     = ALUOP_SUB;
        bus.ResultSrc = RES_ALUOUT;
        bus.PCWrite   = take & ~bad_funct3;
        bus.retire    = ~bad_funct3;
      end
      S_JAL: begin
        // PC <- ALUOut (jump target); ALU forms OldPC+4 for the link write in ALUWB.
        bus.ALUSrcA   = ALUA_OLDPC;
        bus.ALUSrcB   = ALUB_FOUR;
        bus.ImmSrc    = IMM_J;
        bus.ResultSrc = RES_ALUOUT;
        bus.PCWrite   = 1'b1;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : self-checking bench for multicycle_controller (vector table plus multi-cycle sequences).
// Latency : n/a.
// Backpressure: mem_ready driven per cycle to exercise wait states.
module tb_multicycle_controller;
  import riscv_mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // every control output except illegal
  logic [17:0] ctl;
  assign ctl = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUOp, bus.retire};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       lt;
    logic       ltu;
    int         lat;       // cycles FETCH..retire inclusive
    logic [2:0] imm_dec;   // ImmSrc in DECODE
    logic [2:0] imm3;      // cycle 3 selects
    logic [1:0] a3;
    logic [1:0] b3;
    logic [1:0] aluop3;
    logic       pcw3;
    logic       regw_last; // at the retire cycle
    logic [1:0] rsrc_last;
  } vec_t;

  vec_t vecs[14];

  // lw with two wait cycles in FETCH and in MEMREAD
  logic       lw_rdy[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  // {mem_req, AdrSrc, IRWrite, retire, ResultSrc}
  logic [5:0] lw_exp[9] = '{6'b100010, 6'b100010, 6'b101010, 6'b000000, 6'b000000,
                            6'b110000, 6'b110000, 6'b110000, 6'b000101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic l, input logic lu);
    bus.op     = op;
    bus.funct3 = f3;
    bus.zero   = z;
    bus.lt     = l;
    bus.ltu    = lu;
  endtask

  // Called just before the posedge that enters FETCH; returns after sampling the retire cycle.
  task automatic run_vec(input int idx, input vec_t v);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    set_in(v.op, v.f3, v.z, v.lt, v.ltu);
    bus.mem_ready = 1'b1;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (k == 1)
        chk($sformatf("v%0d.fetch", idx),
            {26'd0, bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.ALUSrcB},
            {26'd0, 4'b1011, ALUB_FOUR});
      if (k == 2)
        chk($sformatf("v%0d.decode", idx), {25'd0, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB},
            {25'd0, v.imm_dec, ALUA_OLDPC, ALUB_IMM});
      if (k == 3) begin
        chk($sformatf("v%0d.imm3", idx), 32'(bus.ImmSrc), 32'(v.imm3));
        chk($sformatf("v%0d.srca3", idx), 32'(bus.ALUSrcA), 32'(v.a3));
        chk($sformatf("v%0d.srcb3", idx), 32'(bus.ALUSrcB), 32'(v.b3));
        chk($sformatf("v%0d.aluop3", idx), 32'(bus.ALUOp), 32'(v.aluop3));
        chk($sformatf("v%0d.pcw3", idx), 32'(bus.PCWrite), 32'(v.pcw3));
      end
      if (bus.retire) begin
        chk($sformatf("v%0d.latency", idx), 32'(k), 32'(v.lat));
        chk($sformatf("v%0d.regwrite", idx), 32'(bus.RegWrite), 32'(v.regw_last));
        chk($sformatf("v%0d.resultsrc", idx), 32'(bus.ResultSrc), 32'(v.rsrc_last));
        done = 1'b1;
      end
    end
    chk($sformatf("v%0d.retired", idx), 32'(done), 32'd1);
  endtask

  // Pulse reset across a negedge; leaves the bench just before the posedge that enters FETCH.
  task automatic reset_pulse(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({name, ".rst_ctl"}, {14'd0, ctl}, 32'd0);
    chk({name, ".rst_illegal"}, 32'(bus.illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //              op          f3    z     lt    ltu  lat imm_dec imm3  a3     b3     aluop pcw  regw rsrc
    vecs[0]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b010, 3'b000, 2'b10, 2'b01, 2'b10, 1'b0, 1'b1, 2'b00}; // addi
    vecs[1]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b010, 3'b000, 2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 2'b00}; // add
    vecs[2]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5, 3'b010, 3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01}; // lw
    vecs[3]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4, 3'b010, 3'b001, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00}; // sw
    vecs[4]  = '{7'b1100011, 3'b000, 1'b1, 1'b0, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00}; // beq taken
    vecs[5]  = '{7'b1100011, 3'b001, 1'b1, 1'b0, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00}; // bne z=1
    vecs[6]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00}; // bne z=0
    vecs[7]  = '{7'b1100011, 3'b100, 1'b0, 1'b1, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00}; // blt lt=1
    vecs[8]  = '{7'b1100011, 3'b101, 1'b0, 1'b1, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00}; // bge lt=1
    vecs[9]  = '{7'b1100011, 3'b110, 1'b0, 1'b1, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00}; // bltu ltu=0
    vecs[10] = '{7'b1100011, 3'b111, 1'b0, 1'b1, 1'b0, 3, 3'b010, 3'b000, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00}; // bgeu ltu=0
    vecs[11] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b011, 3'b011, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00}; // jal
    vecs[12] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b010, 3'b100, 2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00}; // lui
    vecs[13] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 4, 3'b010, 3'b100, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00}; // auipc

    // Reset state
    rst_n = 1'b0;
    set_in(7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.ctl", {14'd0, ctl}, 32'd0);
    chk("reset.illegal", 32'(bus.illegal), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("start.ctl", {14'd0, ctl}, 32'd0);

    // Zero-wait instruction table
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // lw with wait states: 9 cycles to retire, request held steady during waits
    @(posedge clk);
    #1;
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      bus.mem_ready = lw_rdy[k];
      @(negedge clk);
      chk($sformatf("lw_wait.c%0d", k + 1),
          {26'd0, bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.retire, bus.ResultSrc},
          {26'd0, lw_exp[k]});
    end

    // sw stalled in MEMWRITE, then reset mid-access
    @(posedge clk);
    #1;
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      bus.mem_ready = (k == 1);
      @(negedge clk);
      if (k >= 4)
        chk($sformatf("sw_wait.c%0d", k), {28'd0, bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.retire},
            {28'd0, 4'b1110});
    end
    rst_n = 1'b0;
    #1;
    chk("sw_rst.ctl", {14'd0, ctl}, 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_rst.hold", {14'd0, ctl}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("sw_rst.start", 32'(bus.mem_req), 32'd0);
    run_vec(100, vecs[0]);  // FETCH resumes on the first edge after release

    // Illegal opcode: TRAP, sticky, no retire
    begin
      int nret;
      nret = 0;
      @(posedge clk);
      #1;
      set_in(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
      bus.mem_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (bus.retire) nret++;
        if (k >= 3)
          chk($sformatf("trap_op.c%0d", k), {13'd0, ctl, bus.illegal}, 32'd1);
      end
      chk("trap_op.retires", 32'(nret), 32'd0);
    end
    reset_pulse("trap_op");

    // Branch with reserved funct3: no PCWrite, no retire, then TRAP
    @(posedge clk);
    #1;
    set_in(7'b1100011, 3'b010, 1'b1, 1'b1, 1'b1);
    bus.mem_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3)
        chk("trap_f3.branch", {29'd0, bus.PCWrite, bus.retire, bus.illegal}, 32'd0);
      if (k >= 4)
        chk($sformatf("trap_f3.c%0d", k), {13'd0, ctl, bus.illegal}, 32'd1);
    end
    reset_pulse("trap_f3");
    run_vec(101, vecs[12]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
